// File: rtl/nonrestoring_divider_su.sv
// ============================================================================
//  Module      : nonrestoring_divider_su
//  Description : Sequential non-restoring divider with per-operand sign
//                selection.
//                One quotient bit is produced per clock. The FSM walks
//                through IDLE -> PREP -> ITER (WIDTH cycles) -> FIX.
//                PREP forms the operand magnitudes. FIX applies the remainder
//                correction and the result signs.
//                Quotient truncates toward zero. The remainder takes the sign
//                of the dividend. Divide-by-zero returns all-ones and the
//                unchanged dividend.
//  Options     : DIVIDER_ZERO_FAST_EN - when defined, PREP detects a zero
//                divisor and jumps straight to FIX (done 2 edges after the
//                start edge instead of WIDTH+2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonrestoring_divider_su #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int                 c_cw       = $clog2(WIDTH);
  localparam logic [c_cw-1:0]    c_last     = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0]    c_cnt_one  = c_cw'(1);
  localparam logic [WIDTH-1:0]   c_one      = WIDTH'(1);
  localparam logic [WIDTH-1:0]   c_ones     = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  // Captured request
  logic [WIDTH-1:0]  r_dividend;
  logic [WIDTH-1:0]  r_divisor;
  logic [1:0]        r_mode;

  // Iteration datapath
  logic [WIDTH:0]    r_p;        // signed partial remainder, one extra bit
  logic [WIDTH-1:0]  r_q;        // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]  r_b;        // divisor magnitude
  logic [c_cw-1:0]   r_count;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_zero;

  // Registered results
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_dbz;
  logic              r_done;

  // Combinational helpers
  logic              w_neg_a;
  logic              w_neg_b;
  logic [WIDTH-1:0]  w_abs_a;
  logic [WIDTH-1:0]  w_abs_b;
  logic [WIDTH:0]    w_b_ext;
  logic [WIDTH:0]    w_p_sh;
  logic [WIDTH:0]    w_p_new;
  logic [WIDTH:0]    w_p_fix;
  logic [WIDTH-1:0]  w_q_signed;
  logic [WIDTH-1:0]  w_r_signed;

  // Operand magnitudes and signs, taken from the captured request
  assign w_neg_a = r_mode[1] & r_dividend[WIDTH-1];
  assign w_neg_b = r_mode[0] & r_divisor[WIDTH-1];
  assign w_abs_a = w_neg_a ? (~r_dividend + c_one) : r_dividend;
  assign w_abs_b = w_neg_b ? (~r_divisor + c_one) : r_divisor;

  // One non-restoring step. The shifted value may exceed WIDTH+1 bits, but the
  // post-add/subtract value always lies in [-b, b), so modular arithmetic is exact.
  assign w_b_ext = {1'b0, r_b};
  assign w_p_sh  = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_p_new = r_p[WIDTH] ? (w_p_sh + w_b_ext) : (w_p_sh - w_b_ext);

  // Final correction: a negative partial remainder still owes one divisor
  assign w_p_fix    = r_p[WIDTH] ? (r_p + w_b_ext) : r_p;
  assign w_q_signed = r_neg_q ? (~r_q + c_one) : r_q;
  assign w_r_signed = r_neg_r ? (~w_p_fix[WIDTH-1:0] + c_one) : w_p_fix[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = PREP;
        end
      end
      PREP: begin
`ifdef DIVIDER_ZERO_FAST_EN
        if (r_divisor == '0) begin
          w_next = FIX;
        end else begin
          w_next = ITER;
        end
`else
        w_next = ITER;
`endif
      end
      ITER: begin
        if (r_count == c_last) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture, magnitude preparation, iteration and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_mode      <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_b         <= '0;
      r_count     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_mode     <= sign_mode;
          end
        end
        PREP: begin
          r_p     <= '0;
          r_q     <= w_abs_a;
          r_b     <= w_abs_b;
          r_count <= '0;
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          r_zero  <= (r_divisor == '0);
        end
        ITER: begin
          r_p     <= w_p_new;
          r_q     <= {r_q[WIDTH-2:0], ~w_p_new[WIDTH]};
          r_count <= r_count + c_cnt_one;
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_zero) begin
            r_quotient  <= c_ones;
            r_remainder <= r_dividend;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= w_q_signed;
            r_remainder <= w_r_signed;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // busy covers the ITER and FIX cycles only. A start seen during PREP has no
  // effect, because capture happens in IDLE alone.
  assign busy        = (r_state == ITER) || (r_state == FIX);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_nonrestoring_divider_su.sv
// ============================================================================
//  Module      : tb_nonrestoring_divider_su
//  Description : Directed, table-driven bench for nonrestoring_divider_su
//                (WIDTH=16). Covers sign modes, overflow, divide-by-zero,
//                back-to-back starts and reset in the middle of an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nonrestoring_divider_su;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [1:0]  sign_mode;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  nonrestoring_divider_su #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  m;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. lat counts edges after the start edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                       output int lat, output int bcnt,
                       output logic [15:0] q, output logic [15:0] r, output logic dz,
                       output logic busy_at_done);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    sign_mode = m;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    q            = quotient;
    r            = remainder;
    dz           = div_by_zero;
    busy_at_done = busy;
  endtask

  function automatic logic [15:0] ops_a(input int n);
    return 16'(1000 + n * 37);
  endfunction

  function automatic logic [15:0] ops_b(input int n);
    return 16'(3 + (n % 5));
  endfunction

  initial begin
    vec_t        vecs[18];
    int          lat;
    int          bcnt;
    int          exp_zero_lat;
    int          exp_zero_busy;
    int          cap_n;
    int          ndone;
    int          last_done;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        bd;
    logic [15:0] hold_q;

`ifdef DIVIDER_ZERO_FAST_EN
    exp_zero_lat  = 2;
    exp_zero_busy = 1;
`else
    exp_zero_lat  = 18;
    exp_zero_busy = 17;
`endif

    vecs[0]  = '{16'h0064, 16'h0007, 2'b00, 16'h000E, 16'h0002, 1'b0};
    vecs[1]  = '{16'hFF9C, 16'h0007, 2'b11, 16'hFFF2, 16'hFFFE, 1'b0};
    vecs[2]  = '{16'h0064, 16'hFFF9, 2'b11, 16'hFFF2, 16'h0002, 1'b0};
    vecs[3]  = '{16'h8000, 16'hFFFF, 2'b11, 16'h8000, 16'h0000, 1'b0};
    vecs[4]  = '{16'h8000, 16'hFFFF, 2'b00, 16'h0000, 16'h8000, 1'b0};
    vecs[5]  = '{16'h04D2, 16'h0000, 2'b00, 16'hFFFF, 16'h04D2, 1'b1};
    vecs[6]  = '{16'h04D2, 16'h0000, 2'b11, 16'hFFFF, 16'h04D2, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'h0001, 2'b00, 16'hFFFF, 16'h0000, 1'b0};
    vecs[8]  = '{16'hFF9C, 16'hFFF9, 2'b11, 16'h000E, 16'hFFFE, 1'b0};
    vecs[9]  = '{16'hFF9C, 16'h0007, 2'b10, 16'hFFF2, 16'hFFFE, 1'b0};
    vecs[10] = '{16'hFF9C, 16'h0007, 2'b00, 16'h2484, 16'h0000, 1'b0};
    vecs[11] = '{16'h0064, 16'hFFF9, 2'b01, 16'hFFF2, 16'h0002, 1'b0};
    vecs[12] = '{16'h0064, 16'hFFF9, 2'b00, 16'h0000, 16'h0064, 1'b0};
    vecs[13] = '{16'h0005, 16'h0007, 2'b00, 16'h0000, 16'h0005, 1'b0};
    vecs[14] = '{16'hFFFF, 16'hFFFF, 2'b11, 16'h0001, 16'h0000, 1'b0};
    vecs[15] = '{16'h0007, 16'h0007, 2'b11, 16'h0001, 16'h0000, 1'b0};
    vecs[16] = '{16'hFFFF, 16'h0002, 2'b10, 16'h0000, 16'hFFFF, 1'b0};
    vecs[17] = '{16'h1234, 16'h0010, 2'b00, 16'h0123, 16'h0004, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    sign_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", 32'(quotient), 32'h0);
    chk("reset_remainder", 32'(remainder), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_dbz", 32'(div_by_zero), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].m, lat, bcnt, q, r, dz, bd);
      chk($sformatf("v%0d_quotient", i), 32'(q), 32'(vecs[i].eq));
      chk($sformatf("v%0d_remainder", i), 32'(r), 32'(vecs[i].er));
      chk($sformatf("v%0d_dbz", i), 32'(dz), 32'(vecs[i].edz));
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].edz ? 32'(exp_zero_lat) : 32'd18);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), vecs[i].edz ? 32'(exp_zero_busy) : 32'd17);
      chk($sformatf("v%0d_busy_in_done", i), 32'(bd), 32'h0);
    end

    // Results hold after the done pulse
    hold_q = quotient;
    @(posedge clk);
    #1;
    chk("hold_done_low", 32'(done), 32'h0);
    chk("hold_quotient", 32'(quotient), 32'(hold_q));

    // start held high with operands changing every cycle
    cap_n     = 0;
    ndone     = 0;
    last_done = -1;
    for (int n = 0; n < 59; n++) begin
      @(negedge clk);
      dividend  = ops_a(n);
      divisor   = ops_b(n);
      sign_mode = 2'b00;
      start     = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        chk($sformatf("b2b%0d_edge", ndone), 32'(n), 32'(cap_n + 18));
        chk($sformatf("b2b%0d_quotient", ndone), 32'(quotient), 32'(ops_a(cap_n) / ops_b(cap_n)));
        chk($sformatf("b2b%0d_remainder", ndone), 32'(remainder), 32'(ops_a(cap_n) % ops_b(cap_n)));
        if (last_done >= 0) begin
          chk($sformatf("b2b%0d_period", ndone), 32'(n - last_done), 32'd19);
        end
        last_done = n;
        cap_n     = n + 1;
      end
    end
    chk("b2b_done_count", 32'(ndone), 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(posedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    dividend  = 16'h1234;
    divisor   = 16'h0003;
    sign_mode = 2'b00;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midop_busy", 32'(busy), 32'h1);
    chk("midop_prior_quotient_nonzero", 32'(quotient != 16'h0), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", 32'(quotient), 32'h0);
    chk("abort_remainder", 32'(remainder), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_dbz", 32'(div_by_zero), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'h0);
    do_op(16'hFFFF, 16'h0001, 2'b00, lat, bcnt, q, r, dz, bd);
    chk("post_reset_quotient", 32'(q), 32'hFFFF);
    chk("post_reset_remainder", 32'(r), 32'h0);
    chk("post_reset_latency", 32'(lat), 32'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nonrestoring_divider_su.md
NONRESTORING_DIVIDER_SU -- requirements
Module: nonrestoring_divider_su

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port dividend  input  WIDTH  numerator, captured with accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  denominator, captured with accepted start.
REQ-007 SHALL have port sign_mode  input  2  [1]=dividend signed, [0]=divisor signed; captured with accepted start.
REQ-008 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-009 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-010 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-012 SHALL have port div_by_zero  output  1  registered with done; divisor was zero.

Function
REQ-013 SHALL use FSM states IDLE, PREP, ITER, FIX; IDLE->PREP on start while busy=0.
REQ-014 PREP SHALL form magnitudes |dividend|, |divisor| per sign_mode and record result signs; PREP->ITER.
REQ-015 ITER SHALL run exactly WIDTH non-restoring iterations, one quotient bit per cycle, WIDTH+1-bit partial remainder; counter reaching WIDTH-1 -> FIX.
REQ-016 FIX SHALL apply remainder restore step (add divisor if partial remainder negative), then signs; FIX->IDLE.
REQ-017 Quotient SHALL truncate toward zero; remainder SHALL take dividend sign; quotient negative iff effective operand signs differ.
REQ-018 Signed overflow (most-negative / -1, both signed) SHALL yield quotient = most-negative value (wrapped), remainder = 0, div_by_zero = 0.
REQ-019 Divisor zero SHALL yield quotient all-ones, remainder = dividend unchanged, div_by_zero = 1, any sign_mode.
REQ-020 Latency: start sampled at edge k -> done=1 during cycle following edge k+WIDTH+2 (18 edges for WIDTH=16).
REQ-021 busy SHALL be 1 from edge after accepted start until edge that asserts done; busy=0 during done cycle.
REQ-022 start during done cycle SHALL be accepted (back-to-back throughput WIDTH+3 cycles).
REQ-023 start while busy=1 SHALL be ignored with no effect on captured operands or results.
REQ-024 quotient, remainder, div_by_zero SHALL hold last result until next done.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-026 Reset mid-operation SHALL abort without done pulse; next start after release SHALL run normally.

Configuration
REQ-027 Macro DIVIDER_ZERO_FAST_EN, when defined, SHALL make PREP detect divisor==0 and go directly to FIX, done after 3 edges (start edge k -> done after edge k+2).
REQ-028 Without DIVIDER_ZERO_FAST_EN, divide-by-zero SHALL take the full REQ-020 latency; results/flag per REQ-019 in both builds.

Verification
REQ-029 Unsigned 100/7, sign_mode=00 -> quotient=14, remainder=2, done exactly 18 edges after start sample, busy high 17 cycles.
REQ-030 Signed -100/7 (0xFF9C/0x0007, sign_mode=11) -> quotient=0xFFF2, remainder=0xFFFE; 100/-7 -> 0xFFF2, 0x0002.
REQ-031 Signed 0x8000/0xFFFF, sign_mode=11 -> quotient=0x8000, remainder=0; unsigned same operands -> quotient=0x0000, remainder=0x8000.
REQ-032 0x04D2/0x0000 -> quotient=0xFFFF, remainder=0x04D2, div_by_zero=1; done after 3 edges with macro, 18 without.
REQ-033 start held high continuously with changing operands -> operands captured only at IDLE/done cycle, results match captured pairs, one done per 19 cycles.
REQ-034 rst_n asserted at iteration 8 -> all outputs 0 asynchronously, no done; following 0xFFFF/0x0001 unsigned -> quotient=0xFFFF, remainder=0.
